// File: rtl/execute_arith_unit.sv
// rtl/execute_arith_unit.sv - RV32I execute-stage PC adders, ALU, branch condition and registered flags
module execute_arith_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      ALUControlE,
    input  logic [2:0]      funct3E,
    output logic [XLEN-1:0] ALUResult,
    output logic            CarryOut,
    output logic            ZeroE,
    output logic [3:0]      FlagsQ
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;
    localparam logic [4:0] OP_CMP   = 5'd11;

    logic [XLEN:0]   sum_ext;
    logic [XLEN:0]   diff_ext;
    logic [4:0]      shamt;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            ovf_add;
    logic            ovf_sub;
    logic            ovf;

    assign PCPlus4F  = PCF + XLEN'(4);
    assign PCTargetE = PCE + ImmExtE;

    // Subtraction shares the adder form A + ~B + 1 so bit XLEN is the "no borrow" carry.
    assign sum_ext  = {1'b0, SrcAE} + {1'b0, SrcBE};
    assign diff_ext = {1'b0, SrcAE} + {1'b0, ~SrcBE} + {{XLEN{1'b0}}, 1'b1};
    assign shamt    = SrcBE[4:0];

    assign lt_unsigned = ~diff_ext[XLEN];
    assign lt_signed   = (SrcAE[XLEN-1] != SrcBE[XLEN-1]) ? SrcAE[XLEN-1] : diff_ext[XLEN-1];

    assign ovf_add = (SrcAE[XLEN-1] == SrcBE[XLEN-1]) && (sum_ext[XLEN-1] != SrcAE[XLEN-1]);
    assign ovf_sub = (SrcAE[XLEN-1] != SrcBE[XLEN-1]) && (diff_ext[XLEN-1] != SrcAE[XLEN-1]);

    always_comb begin
        ALUResult = '0;
        CarryOut  = 1'b0;
        ovf       = 1'b0;
        case (ALUControlE)
            OP_ADD: begin
                ALUResult = sum_ext[XLEN-1:0];
                CarryOut  = sum_ext[XLEN];
                ovf       = ovf_add;
            end
            OP_SUB, OP_CMP: begin
                ALUResult = diff_ext[XLEN-1:0];
                CarryOut  = diff_ext[XLEN];
                ovf       = ovf_sub;
            end
            OP_SLL:   ALUResult = SrcAE << shamt;
            OP_SLT:   ALUResult = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU:  ALUResult = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_XOR:   ALUResult = SrcAE ^ SrcBE;
            OP_SRL:   ALUResult = SrcAE >> shamt;
            OP_SRA:   ALUResult = $unsigned($signed(SrcAE) >>> shamt);
            OP_OR:    ALUResult = SrcAE | SrcBE;
            OP_AND:   ALUResult = SrcAE & SrcBE;
            OP_PASSB: ALUResult = SrcBE;
            default:  ALUResult = '0;
        endcase
    end

    // Raw branch condition; the branch enable is applied by the caller.
    always_comb begin
        ZeroE = 1'b0;
        case (funct3E)
            3'b000:  ZeroE = (SrcAE == SrcBE);
            3'b001:  ZeroE = (SrcAE != SrcBE);
            3'b100:  ZeroE = lt_signed;
            3'b101:  ZeroE = ~lt_signed;
            3'b110:  ZeroE = lt_unsigned;
            3'b111:  ZeroE = ~lt_unsigned;
            default: ZeroE = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            FlagsQ <= 4'b0000;
        end else begin
            FlagsQ <= {ALUResult[XLEN-1], (ALUResult == '0), CarryOut, ovf};
        end
    end

endmodule

// File: tb/tb_execute_arith_unit.sv
// tb/tb_execute_arith_unit.sv - randomized and directed bench for execute_arith_unit
module tb_execute_arith_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCPlus4F, PCE, ImmExtE, PCTargetE;
    logic [31:0] SrcAE, SrcBE, ALUResult;
    logic [4:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic        CarryOut, ZeroE;
    logic [3:0]  FlagsQ;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_flags;

    execute_arith_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .PCF(PCF), .PCPlus4F(PCPlus4F),
        .PCE(PCE), .ImmExtE(ImmExtE), .PCTargetE(PCTargetE),
        .SrcAE(SrcAE), .SrcBE(SrcBE),
        .ALUControlE(ALUControlE), .funct3E(funct3E),
        .ALUResult(ALUResult), .CarryOut(CarryOut), .ZeroE(ZeroE),
        .FlagsQ(FlagsQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural meaning of each op.
    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        int     sh = int'(b % 32);
        longint t;
        case (op)
            0:  t = ua + ub;
            1:  t = ua - ub;
            2:  t = ua * (64'sd1 <<< sh);
            3:  t = (sa < sb) ? 1 : 0;
            4:  t = (ua < ub) ? 1 : 0;
            5:  t = ua ^ ub;
            6:  t = ua / (64'sd1 <<< sh);
            7:  t = (sa >= 0) ? sa / (64'sd1 <<< sh) : -((-sa + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh));
            8:  t = ua | ub;
            9:  t = ua & ub;
            10: t = ub;
            11: t = ua - ub;
            default: t = 0;
        endcase
        return t[31:0];
    endfunction

    function automatic logic ref_carry(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        if (op == 0)  return (ua + ub) >= 64'sd4294967296;
        if (op == 1 || op == 11) return ua >= ub;
        return 1'b0;
    endfunction

    function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        if (op == 0) t = sa + sb;
        else if (op == 1 || op == 11) t = sa - sb;
        else return 1'b0;
        return (t > 64'sd2147483647) || (t < -64'sd2147483648);
    endfunction

    function automatic logic ref_zero(input int f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (f3)
            0: return ua == ub;
            1: return ua != ub;
            4: return sa < sb;
            5: return sa >= sb;
            6: return ua < ub;
            7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one vector just after a rising edge, check the combinational outputs and
    // record the flags the next edge should capture.
    task automatic apply(input int op, input int f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pcf, input logic [31:0] pce, input logic [31:0] imm);
        logic [31:0] r;
        logic        c;
        ALUControlE = 5'(op);
        funct3E     = 3'(f3);
        SrcAE = a; SrcBE = b; PCF = pcf; PCE = pce; ImmExtE = imm;
        #1;
        r = ref_result(op, a, b);
        c = ref_carry(op, a, b);
        check($sformatf("result op%0d", op), ALUResult, r);
        check($sformatf("carry op%0d", op), {31'd0, CarryOut}, {31'd0, c});
        check($sformatf("zero f3=%0d", f3), {31'd0, ZeroE}, {31'd0, ref_zero(f3, a, b)});
        check("pcplus4", PCPlus4F, 32'(longint'({32'd0, pcf}) + 4));
        check("pctarget", PCTargetE, 32'(longint'({32'd0, pce}) + longint'({32'd0, imm})));
        exp_flags = rst ? {r[31], (r == 32'd0), c, ref_ovf(op, a, b)} : 4'b0000;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check(tag, {28'd0, FlagsQ}, {28'd0, exp_flags});
    endtask

    initial begin
        rst = 1'b0;
        PCF = '0; PCE = '0; ImmExtE = '0; SrcAE = '0; SrcBE = '0;
        ALUControlE = '0; funct3E = '0;
        @(posedge clk); #1;
        check("reset flags", {28'd0, FlagsQ}, 32'd0);

        // Reset held across two edges with live ALU activity
        apply(1, 0, 32'd5, 32'd7, 32'h10, 32'h100, 32'hFFFFFFF8);
        tick("rst hold 1");
        apply(0, 1, 32'h7FFFFFFF, 32'd1, 32'h20, 32'h40, 32'h4);
        tick("rst hold 2");
        rst = 1'b1;
        apply(0, 1, 32'h7FFFFFFF, 32'd1, 32'h20, 32'h40, 32'h4);
        tick("rst release");
        check("release flags", {28'd0, FlagsQ}, 32'h9);

        apply(0, 0, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h100, 32'hFFFFFFF8);
        check("pc4 0x10", PCPlus4F, 32'h14);
        check("pctarget 0xF8", PCTargetE, 32'hF8);
        check("add wrap res", ALUResult, 32'h0);
        check("add wrap carry", {31'd0, CarryOut}, 32'd1);
        tick("flags add wrap");

        apply(1, 0, 32'd5, 32'd7, 32'hFFFFFFFC, 32'h0, 32'h0);
        check("pc4 wrap", PCPlus4F, 32'h0);
        check("sub res", ALUResult, 32'hFFFFFFFE);
        check("sub carry", {31'd0, CarryOut}, 32'd0);
        tick("flags sub");
        check("sub flags 1000", {28'd0, FlagsQ}, 32'h8);

        apply(3, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        check("slt -1<1", ALUResult, 32'd1);
        apply(4, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        check("sltu", ALUResult, 32'd0);
        apply(7, 0, 32'h80000000, 32'd4, 0, 0, 0);
        check("sra", ALUResult, 32'hF8000000);
        apply(6, 0, 32'h80000000, 32'd4, 0, 0, 0);
        check("srl", ALUResult, 32'h08000000);
        apply(2, 0, 32'h00000003, 32'h21, 0, 0, 0);
        check("sll b=0x21", ALUResult, 32'h6);
        apply(20, 0, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
        check("unused op res", ALUResult, 32'd0);
        check("unused op carry", {31'd0, CarryOut}, 32'd0);
        tick("flags unused");

        begin
            logic [2:0] f3s [7] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
            logic       zs  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 7; i++) begin
                apply(0, int'(f3s[i]), 32'hFFFFFFFE, 32'd3, 0, 0, 0);
                check($sformatf("sweep f3=%0d", f3s[i]), {31'd0, ZeroE}, {31'd0, zs[i]});
            end
        end

        apply(0, 0, 32'h7FFFFFFF, 32'd1, 0, 0, 0);
        check("ovf add res", ALUResult, 32'h80000000);
        tick("flags ovf");
        check("ovf flags N,V", {28'd0, FlagsQ}, 32'h9);

        for (int i = 0; i < 400; i++) begin
            int op, f3;
            logic [31:0] a, b;
            op = (($urandom % 8) == 0) ? int'($urandom_range(12, 31)) : int'($urandom_range(0, 11));
            f3 = int'($urandom % 8);
            a  = $urandom;
            b  = $urandom;
            case ($urandom % 5)
                0: b = a;
                1: a = {1'b1, 31'(a)} ^ (a & 32'h7FFFFFFF) & 32'h80000000;
                2: b = b & 32'h3F;
                default: ;
            endcase
            apply(op, f3, a, b, $urandom, $urandom, $urandom);
            if ((i % 3) == 0) tick("rand flags");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
